dmem_arbiter: RTL and testbench

Two-port arbiter placed in front of the single-ported data memory, which has a combinational read and a write on the clock edge. It shares the memory between requester 0 (core load/store unit) and requester 1 (debug/DMA port).

- Each cycle it grants at most one requester and drives the memory's write-enable, address and write-data.
- It returns a registered response (read data, completion, error) to the granted requester one cycle later.
- Arbitration is round-robin, with a bounded lock that lets a requester perform short atomic sequences.

---
 rtl/dmem_arbiter_if.sv | 50 +++++
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-ported data memory.
// Handshake: a requester raises pN_req with we/lock/addr/wdata and holds them stable until
// it sees pN_gnt in the same cycle; the access completes that cycle and pN_rvalid pulses
// exactly one cycle later with pN_rdata/pN_err. There is no backpressure on the response.
interface dmem_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic        p0_lock;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_gnt;
  logic        p0_rvalid;
  logic [31:0] p0_rdata;
  logic        p0_err;

  logic        p1_req;
  logic        p1_we;
  logic        p1_lock;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_gnt;
  logic        p1_rvalid;
  logic [31:0] p1_rdata;
  logic        p1_err;

  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  // Arbiter side
  modport slave (
    input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata, p1_err,
    output mem_we, mem_a, mem_wd,
    input  mem_rd
  );

  // Requester and memory side
  modport master (
    output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
    output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
    input  mem_we, mem_a, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of a single-ported data memory, with a bounded
// lock so one requester can run short atomic sequences. Internal state is exposed on o_dbg_*.
module dmem_arbiter #(
  parameter int MEM_SIZE = 64,
  parameter int MAX_HOLD = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  dmem_arbiter_if.slave                  bus,
  output logic                           o_dbg_last,
  output logic                           o_dbg_owner_valid,
  output logic                           o_dbg_owner,
  output logic [$clog2(MAX_HOLD+1)-1:0]  o_dbg_hold_cnt
);
  localparam int              HW         = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]   MAX_HOLD_C = HW'(MAX_HOLD);
  localparam logic [31:0]     MEM_SIZE_C = 32'(MEM_SIZE);

  logic          r_last;
  logic          r_owner_valid;
  logic          r_owner;
  logic [HW-1:0] r_hold_cnt;
  logic [1:0]    r_rvalid;
  logic [1:0]    r_err;
  logic [31:0]   r_rdata0;
  logic [31:0]   r_rdata1;

  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_lock_ovr;
  logic          w_any;
  logic          w_g;
  logic          w_sel_we;
  logic          w_sel_lock;
  logic [31:0]   w_sel_addr;
  logic [31:0]   w_sel_wdata;
  logic          w_in_range;
  logic          w_mem_en;
  logic [31:0]   w_rd_val;

  // Grants are gated by reset so no write can reach the memory while reset is low.
  always_comb begin
    w_gnt0     = 1'b0;
    w_gnt1     = 1'b0;
    w_lock_ovr = r_owner_valid && (r_hold_cnt < MAX_HOLD_C) &&
                 (r_owner ? bus.p1_lock : bus.p0_lock);
    if (reset) begin
      if (bus.p0_req && !bus.p1_req) begin
        w_gnt0 = 1'b1;
      end else if (bus.p1_req && !bus.p0_req) begin
        w_gnt1 = 1'b1;
      end else if (bus.p0_req && bus.p1_req) begin
        if (w_lock_ovr) begin
          w_gnt0 = !r_owner;
          w_gnt1 = r_owner;
        end else begin
          w_gnt0 = r_last;
          w_gnt1 = !r_last;
        end
      end
    end
  end

  assign w_any       = w_gnt0 | w_gnt1;
  assign w_g         = w_gnt1;
  assign w_sel_we    = w_g ? bus.p1_we    : bus.p0_we;
  assign w_sel_lock  = w_g ? bus.p1_lock  : bus.p0_lock;
  assign w_sel_addr  = w_g ? bus.p1_addr  : bus.p0_addr;
  assign w_sel_wdata = w_g ? bus.p1_wdata : bus.p0_wdata;
  assign w_in_range  = w_sel_addr < MEM_SIZE_C;
  assign w_mem_en    = w_any && w_in_range;
  assign w_rd_val    = (w_in_range && !w_sel_we) ? bus.mem_rd : 32'd0;

  // Out-of-range accesses still complete, but never touch the memory bus.
  assign bus.mem_we  = w_mem_en && w_sel_we;
  assign bus.mem_a   = w_mem_en ? w_sel_addr  : 32'd0;
  assign bus.mem_wd  = w_mem_en ? w_sel_wdata : 32'd0;

  assign bus.p0_gnt    = w_gnt0;
  assign bus.p1_gnt    = w_gnt1;
  assign bus.p0_rvalid = r_rvalid[0];
  assign bus.p1_rvalid = r_rvalid[1];
  assign bus.p0_rdata  = r_rdata0;
  assign bus.p1_rdata  = r_rdata1;
  assign bus.p0_err    = r_err[0];
  assign bus.p1_err    = r_err[1];

  assign o_dbg_last        = r_last;
  assign o_dbg_owner_valid = r_owner_valid;
  assign o_dbg_owner       = r_owner;
  assign o_dbg_hold_cnt    = r_hold_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last        <= 1'b1;
      r_owner_valid <= 1'b0;
      r_owner       <= 1'b0;
      r_hold_cnt    <= '0;
      r_rvalid      <= 2'b00;
      r_err         <= 2'b00;
      r_rdata0      <= 32'd0;
      r_rdata1      <= 32'd0;
    end else if (w_any) begin
      r_last   <= w_g;
      r_rvalid <= w_g ? 2'b10 : 2'b01;
      if (w_g) begin
        r_rdata1 <= w_rd_val;
        r_err[1] <= !w_in_range;
      end else begin
        r_rdata0 <= w_rd_val;
        r_err[0] <= !w_in_range;
      end
      // A lock only extends a streak when the same port keeps it back-to-back.
      if (w_sel_lock) begin
        r_owner       <= w_g;
        r_owner_valid <= 1'b1;
        if (r_owner_valid && (r_owner == w_g)) begin
          r_hold_cnt <= (r_hold_cnt == MAX_HOLD_C) ? MAX_HOLD_C : r_hold_cnt + 1'b1;
        end else begin
          r_hold_cnt <= HW'(1);
        end
      end else begin
        r_owner_valid <= 1'b0;
        r_hold_cnt    <= '0;
      end
    end else begin
      r_rvalid      <= 2'b00;
      r_owner_valid <= 1'b0;
      r_hold_cnt    <= '0;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 64-word memory attached to the bus.
module tb_dmem_arbiter;
  logic        clk;
  logic        reset;
  logic        mem_init;
  logic        dbg_last;
  logic        dbg_owner_valid;
  logic        dbg_owner;
  logic [2:0]  dbg_hold;
  logic [31:0] mem [0:63];
  int          checks;
  int          failures;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.MEM_SIZE(64), .MAX_HOLD(4)) u_dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus.slave),
    .o_dbg_last        (dbg_last),
    .o_dbg_owner_valid (dbg_owner_valid),
    .o_dbg_owner       (dbg_owner),
    .o_dbg_hold_cnt    (dbg_hold)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rd = mem[bus.mem_a[5:0]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_a[5:0]] <= bus.mem_wd;
    end
  end

  // driver tasks
  task automatic clear_inputs();
    bus.p0_req = 0; bus.p0_we = 0; bus.p0_lock = 0; bus.p0_addr = 0; bus.p0_wdata = 0;
    bus.p1_req = 0; bus.p1_we = 0; bus.p1_lock = 0; bus.p1_addr = 0; bus.p1_wdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_lock = 1; bus.p0_addr = 3;
    @(posedge clk); #1;
    checks++; if (bus.p0_rvalid !== 1'b1) begin failures++; $display("FAIL rst_pre_rvalid got=%0b exp=1", bus.p0_rvalid); end
    checks++; if (dbg_owner_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_owner got=%0b exp=1", dbg_owner_valid); end
    bus.p0_we = 1; bus.p0_wdata = 32'hCAFE_0003;
    reset = 1'b0;
    #1;
    checks++; if ({bus.p0_gnt, bus.p1_gnt, bus.mem_we, bus.mem_a, bus.mem_wd} !== 67'd0) begin
      failures++; $display("FAIL rst_comb got=%h exp=0", {bus.p0_gnt, bus.p1_gnt, bus.mem_we, bus.mem_a, bus.mem_wd}); end
    checks++; if ({bus.p0_rvalid, bus.p0_rdata, bus.p0_err, bus.p1_rvalid, bus.p1_rdata, bus.p1_err} !== 68'd0) begin
      failures++; $display("FAIL rst_resp got=%h exp=0", {bus.p0_rvalid, bus.p0_rdata, bus.p0_err, bus.p1_rvalid, bus.p1_rdata, bus.p1_err}); end
    checks++; if ({dbg_last, dbg_owner_valid, dbg_hold} !== 5'b10000) begin
      failures++; $display("FAIL rst_state got=%b exp=10000", {dbg_last, dbg_owner_valid, dbg_hold}); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mem[3] !== 32'h1000_0003) begin failures++; $display("FAIL rst_no_write got=%h exp=10000003", mem[3]); end
    checks++; if (bus.p0_gnt !== 1'b0) begin failures++; $display("FAIL rst_gnt_held got=%0b exp=0", bus.p0_gnt); end
    clear_inputs();
    reset = 1'b1;
  endtask

  task automatic test_write_read();
    do_reset();
    @(negedge clk);
    bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 5; bus.p0_wdata = 32'hDEAD_BEEF;
    #1;
    checks++; if ({bus.p0_gnt, bus.p1_gnt, bus.mem_we} !== 3'b101) begin failures++; $display("FAIL wr_gnt got=%b exp=101", {bus.p0_gnt, bus.p1_gnt, bus.mem_we}); end
    checks++; if ({bus.mem_a, bus.mem_wd} !== {32'd5, 32'hDEAD_BEEF}) begin failures++; $display("FAIL wr_bus got=%h exp=00000005deadbeef", {bus.mem_a, bus.mem_wd}); end
    @(posedge clk); #1;
    checks++; if ({bus.p0_rvalid, bus.p0_err, bus.p0_rdata} !== {2'b10, 32'd0}) begin failures++; $display("FAIL wr_resp got=%h exp=200000000", {bus.p0_rvalid, bus.p0_err, bus.p0_rdata}); end
    checks++; if (mem[5] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_mem got=%h exp=deadbeef", mem[5]); end
    @(negedge clk);
    bus.p0_we = 0;
    #1;
    checks++; if ({bus.p0_gnt, bus.mem_we} !== 2'b10) begin failures++; $display("FAIL rd_gnt got=%b exp=10", {bus.p0_gnt, bus.mem_we}); end
    @(posedge clk); #1;
    checks++; if ({bus.p0_rvalid, bus.p0_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin failures++; $display("FAIL rd_resp got=%h exp=1deadbeef", {bus.p0_rvalid, bus.p0_rdata}); end
    @(negedge clk);
    bus.p0_req = 0;
    #1;
    checks++; if (bus.p0_gnt !== 1'b0) begin failures++; $display("FAIL idle_gnt got=%0b exp=0", bus.p0_gnt); end
    @(posedge clk); #1;
    checks++; if ({bus.p0_rvalid, bus.p0_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin failures++; $display("FAIL idle_keep got=%h exp=0deadbeef", {bus.p0_rvalid, bus.p0_rdata}); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    clear_inputs();
    bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 7; bus.p0_wdata = 32'hA5A5_0007;
    #1;
    checks++; if (bus.p0_gnt !== 1'b1) begin failures++; $display("FAIL b2b_wr_gnt got=%0b exp=1", bus.p0_gnt); end
    @(posedge clk); #1;
    checks++; if (bus.p0_rvalid !== 1'b1) begin failures++; $display("FAIL b2b_wr_rvalid got=%0b exp=1", bus.p0_rvalid); end
    @(negedge clk);
    bus.p0_req = 0; bus.p0_we = 0;
    bus.p1_req = 1; bus.p1_addr = 7;
    #1;
    checks++; if ({bus.p0_gnt, bus.p1_gnt} !== 2'b01) begin failures++; $display("FAIL b2b_rd_gnt got=%b exp=01", {bus.p0_gnt, bus.p1_gnt}); end
    @(posedge clk); #1;
    checks++; if ({bus.p0_rvalid, bus.p1_rvalid, bus.p1_rdata} !== {2'b01, 32'hA5A5_0007}) begin
      failures++; $display("FAIL b2b_rd_resp got=%h exp=1a5a50007", {bus.p0_rvalid, bus.p1_rvalid, bus.p1_rdata}); end
  endtask

  task automatic test_round_robin();
    int g;
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.p0_req = 1; bus.p0_addr = 10;
      bus.p1_req = 1; bus.p1_addr = 20;
      g = i % 2;
      a = (g == 0) ? 32'd10 : 32'd20;
      #1;
      checks++; if ({bus.p0_gnt, bus.p1_gnt} !== {g == 0, g == 1}) begin
        failures++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, {bus.p0_gnt, bus.p1_gnt}, {g == 0, g == 1}); end
      checks++; if (bus.mem_a !== a) begin failures++; $display("FAIL rr_addr[%0d] got=%0d exp=%0d", i, bus.mem_a, a); end
      @(posedge clk); #1;
      checks++; if ({bus.p0_rvalid, bus.p1_rvalid} !== {g == 0, g == 1}) begin
        failures++; $display("FAIL rr_rvalid[%0d] got=%b exp=%b", i, {bus.p0_rvalid, bus.p1_rvalid}, {g == 0, g == 1}); end
      checks++; if (((g == 0) ? bus.p0_rdata : bus.p1_rdata) !== 32'h1000_0000 + a) begin
        failures++; $display("FAIL rr_rdata[%0d] got=%h exp=%h", i, (g == 0) ? bus.p0_rdata : bus.p1_rdata, 32'h1000_0000 + a); end
    end
  endtask

  task automatic test_lock_bound();
    int g_exp [10];
    int h_exp [10];
    g_exp = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    h_exp = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.p1_req = 1; bus.p1_lock = 1; bus.p1_addr = 30;
      bus.p0_req = (i > 0); bus.p0_addr = 31;
      #1;
      checks++; if ({bus.p0_gnt, bus.p1_gnt} !== {g_exp[i] == 0, g_exp[i] == 1}) begin
        failures++; $display("FAIL lock_gnt[%0d] got=%b exp=%b", i, {bus.p0_gnt, bus.p1_gnt}, {g_exp[i] == 0, g_exp[i] == 1}); end
      @(posedge clk); #1;
      checks++; if (dbg_hold !== 3'(h_exp[i])) begin failures++; $display("FAIL lock_hold[%0d] got=%0d exp=%0d", i, dbg_hold, h_exp[i]); end
      checks++; if ({bus.p0_rvalid, bus.p1_rvalid} !== {g_exp[i] == 0, g_exp[i] == 1}) begin
        failures++; $display("FAIL lock_rvalid[%0d] got=%b exp=%b", i, {bus.p0_rvalid, bus.p1_rvalid}, {g_exp[i] == 0, g_exp[i] == 1}); end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.p0_req = 0;
      #1;
      checks++; if ({bus.p0_gnt, bus.p1_gnt} !== 2'b01) begin failures++; $display("FAIL solo_gnt[%0d] got=%b exp=01", i, {bus.p0_gnt, bus.p1_gnt}); end
      @(posedge clk); #1;
      checks++; if (dbg_hold !== ((i < 3) ? 3'(i + 1) : 3'd4)) begin
        failures++; $display("FAIL solo_hold[%0d] got=%0d exp=%0d", i, dbg_hold, (i < 3) ? i + 1 : 4); end
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    @(negedge clk);
    bus.p1_req = 1; bus.p1_we = 1; bus.p1_addr = 64; bus.p1_wdata = 32'h5555_5555;
    #1;
    checks++; if ({bus.p1_gnt, bus.mem_we} !== 2'b10) begin failures++; $display("FAIL oor_gnt got=%b exp=10", {bus.p1_gnt, bus.mem_we}); end
    checks++; if ({bus.mem_a, bus.mem_wd} !== 64'd0) begin failures++; $display("FAIL oor_bus got=%h exp=0", {bus.mem_a, bus.mem_wd}); end
    @(posedge clk); #1;
    checks++; if ({bus.p1_rvalid, bus.p1_err, bus.p1_rdata} !== {2'b11, 32'd0}) begin failures++; $display("FAIL oor_resp got=%h exp=300000000", {bus.p1_rvalid, bus.p1_err, bus.p1_rdata}); end
    checks++; if (mem[0] !== 32'h1000_0000) begin failures++; $display("FAIL oor_mem0 got=%h exp=10000000", mem[0]); end
    @(negedge clk);
    bus.p1_we = 0; bus.p1_addr = 32'hFFFF_FFFF;
    #1;
    checks++; if ({bus.p1_gnt, bus.mem_we, bus.mem_a} !== {2'b10, 32'd0}) begin failures++; $display("FAIL oor_rd_gnt got=%h exp=200000000", {bus.p1_gnt, bus.mem_we, bus.mem_a}); end
    @(posedge clk); #1;
    checks++; if ({bus.p1_err, bus.p1_rdata} !== {1'b1, 32'd0}) begin failures++; $display("FAIL oor_rd_resp got=%h exp=100000000", {bus.p1_err, bus.p1_rdata}); end
    @(negedge clk);
    bus.p1_addr = 63;
    #1;
    checks++; if (bus.mem_a !== 32'd63) begin failures++; $display("FAIL top_addr got=%0d exp=63", bus.mem_a); end
    @(posedge clk); #1;
    checks++; if ({bus.p1_err, bus.p1_rdata} !== {1'b0, 32'h1000_003F}) begin failures++; $display("FAIL top_resp got=%h exp=01000003f", {bus.p1_err, bus.p1_rdata}); end
  endtask

  task automatic test_lock_break();
    do_reset();
    @(negedge clk);
    bus.p0_req = 1; bus.p0_lock = 1; bus.p0_addr = 1;
    #1;
    checks++; if (bus.p0_gnt !== 1'b1) begin failures++; $display("FAIL brk_gnt0 got=%0b exp=1", bus.p0_gnt); end
    @(posedge clk); #1;
    checks++; if ({dbg_owner_valid, dbg_owner, dbg_last} !== 3'b100) begin failures++; $display("FAIL brk_owner got=%b exp=100", {dbg_owner_valid, dbg_owner, dbg_last}); end
    @(negedge clk);
    bus.p0_req = 0;
    #1;
    checks++; if ({bus.p0_gnt, bus.p1_gnt} !== 2'b00) begin failures++; $display("FAIL brk_idle_gnt got=%b exp=00", {bus.p0_gnt, bus.p1_gnt}); end
    @(posedge clk); #1;
    checks++; if ({dbg_owner_valid, dbg_hold, bus.p0_rvalid} !== 5'b00000) begin failures++; $display("FAIL brk_cleared got=%b exp=00000", {dbg_owner_valid, dbg_hold, bus.p0_rvalid}); end
    @(negedge clk);
    bus.p0_req = 1; bus.p1_req = 1; bus.p1_addr = 2;
    #1;
    checks++; if ({bus.p0_gnt, bus.p1_gnt} !== 2'b01) begin failures++; $display("FAIL brk_contend got=%b exp=01", {bus.p0_gnt, bus.p1_gnt}); end
    @(posedge clk); #1;
    checks++; if ({bus.p1_rvalid, bus.p1_rdata} !== {1'b1, 32'h1000_0002}) begin failures++; $display("FAIL brk_resp got=%h exp=110000002", {bus.p1_rvalid, bus.p1_rdata}); end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_inputs();
    reset    = 1'b0;
    mem_init = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    reset    = 1'b1;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_round_robin();
    test_lock_bound();
    test_out_of_range();
    test_lock_break();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
